load_store_unit: RTL and testbench
==================================

LOAD_STORE_UNIT -- requirements
Module: load_store_unit

Interface
REQ-001 Parameter MEM_LAT, default 0: extra cycles between mem_raddr becoming stable and mem_rdata being sampled.
REQ-002 clk  input  1  sole clock; all state updates on rising edge.
REQ-003 rst  input  1  asynchronous, active-high reset.
REQ-004 req_valid  input  1  upstream request present.
REQ-005 req_ready  output  1  unit can accept a request this cycle.
REQ-006 req_we  input  1  1 = store, 0 = load.
REQ-007 req_addr  input  8  data-memory address.
REQ-008 req_wdata  input  8  store data.
REQ-009 req_rd  input  3  destination register tag for loads.
REQ-010 mem_en  output  1  write enable to data memory.
REQ-011 mem_waddr  output  8  data-memory write address.
REQ-012 mem_wdata  output  8  data-memory write data.
REQ-013 mem_raddr  output  8  data-memory read address.
REQ-014 mem_rdata  input  8  data-memory read data, combinational from mem_raddr.
REQ-015 rsp_valid  output  1  load result present.
REQ-016 rsp_ready  input  1  downstream writeback accepts result.
REQ-017 rsp_data  output  8  loaded value.
REQ-018 rsp_rd  output  3  tag of loaded value.
REQ-019 st_cnt  output  8  count of accepted stores, wraps 255 -> 0.

Function
REQ-020 FSM states IDLE, STORE, LOAD, RESP; req_ready SHALL be 1 only in IDLE.
REQ-021 Accept = req_valid && req_ready at a rising edge; addr, wdata, rd SHALL be registered on accept and held until return to IDLE.
REQ-022 Store accept: IDLE -> STORE; mem_en SHALL be 1 for exactly the one STORE cycle with registered addr/data on mem_waddr/mem_wdata; STORE -> IDLE unconditionally; no response generated.
REQ-023 st_cnt SHALL increment by 1 (mod 256) at every store accept.
REQ-024 Load accept: IDLE -> LOAD; mem_raddr SHALL carry the registered address from the cycle after accept; LOAD SHALL last MEM_LAT+1 cycles, and mem_rdata SHALL be captured at its final edge, then -> RESP.
REQ-025 Load latency: rsp_valid SHALL rise MEM_LAT+1 cycles after the accept edge.
REQ-026 In RESP, rsp_valid=1 and rsp_data/rsp_rd SHALL stay stable until rsp_ready=1; RESP -> IDLE on the edge where rsp_ready=1.
REQ-027 rsp_ready already high on RESP entry SHALL complete the handshake in that first RESP cycle.
REQ-028 mem_en SHALL be 0 in every state except STORE; mem_waddr/mem_wdata SHALL be don't-care while mem_en=0.
REQ-029 req_valid while busy SHALL be ignored with no side effects; upstream holds the request.

Reset
REQ-030 While rst=1: state IDLE, req_ready=1, mem_en=0, rsp_valid=0, rsp_data=0, rsp_rd=0, st_cnt=0, mem_raddr=0, mem_waddr=0, mem_wdata=0, asynchronously.
REQ-031 Reset during STORE SHALL drop mem_en immediately; reset during LOAD/RESP SHALL discard the pending load without issuing a response.

Configuration
REQ-032 Macro LSU_STORE_FWD_EN defined: the unit SHALL hold last-store address/data plus a valid bit (set on store accept, cleared by reset).
REQ-033 With LSU_STORE_FWD_EN, a load whose address equals the valid last-store address SHALL go IDLE -> RESP in one cycle with the stored data, not waiting MEM_LAT+1 cycles.
REQ-034 Without LSU_STORE_FWD_EN, every load SHALL take the LOAD path of REQ-024 and no forwarding storage SHALL exist.

Verification
REQ-035 After reset, store addr=0x10 data=0xA5 -> mem_en=1 for exactly one cycle with mem_waddr=0x10, mem_wdata=0xA5; st_cnt=1; rsp_valid stays 0.
REQ-036 MEM_LAT=0, load addr=0x20, mem model returns 0x3C, rd=5 -> rsp_valid one cycle after accept with rsp_data=0x3C, rsp_rd=5.
REQ-037 Load with rsp_ready held 0 for 4 cycles -> rsp_valid/rsp_data stable for 4 cycles, req_ready=0 throughout; IDLE the cycle after rsp_ready=1.
REQ-038 256 back-to-back stores -> st_cnt wraps to 0; every store produces a single mem_en pulse.
REQ-039 rst asserted mid-STORE and mid-RESP -> mem_en and rsp_valid fall same cycle; the next request is accepted normally.
REQ-040 LSU_STORE_FWD_EN, store 0x44 -> 0x7E, then load 0x44 -> rsp_data=0x7E one cycle after accept, memory read bypassed; load 0x45 takes the normal MEM_LAT+1 path.

Source files
------------

// File: rtl/load_store_unit.sv
// -----------------------------------------------------------------------------
// load_store_unit
//
// Single-outstanding load/store unit sitting between an issue stage and a
// simple data memory. One request is accepted at a time from IDLE; a store
// drives a one-cycle memory write, and a load presents its address to the
// memory, waits MEM_LAT+1 cycles, captures the read data and holds it on the
// response port until writeback accepts it.
//
// Optional build macro:
//   LSU_STORE_FWD_EN  keep the address/data of the most recent store; a load
//                     that hits it skips the memory wait and responds on the
//                     cycle after accept.
//
// Parameters:
//   MEM_LAT     extra cycles between mem_raddr settling and mem_rdata capture
//
// Ports:
//   clk, rst    clock (rising edge) and asynchronous active-high reset
//   req_*       request channel: valid/ready, we (1 = store), addr, wdata,
//               rd (destination tag for loads)
//   mem_en      data-memory write enable (high only in the store cycle)
//   mem_waddr   data-memory write address
//   mem_wdata   data-memory write data
//   mem_raddr   data-memory read address
//   mem_rdata   data-memory read data (combinational from mem_raddr)
//   rsp_*       load response channel: valid/ready, data, rd tag
//   st_cnt      number of accepted stores, modulo 256
// -----------------------------------------------------------------------------
module load_store_unit #(
    parameter int MEM_LAT = 0
) (
    input  logic       clk,
    input  logic       rst,

    input  logic       req_valid,
    output logic       req_ready,
    input  logic       req_we,
    input  logic [7:0] req_addr,
    input  logic [7:0] req_wdata,
    input  logic [2:0] req_rd,

    output logic       mem_en,
    output logic [7:0] mem_waddr,
    output logic [7:0] mem_wdata,
    output logic [7:0] mem_raddr,
    input  logic [7:0] mem_rdata,

    output logic       rsp_valid,
    input  logic       rsp_ready,
    output logic [7:0] rsp_data,
    output logic [2:0] rsp_rd,

    output logic [7:0] st_cnt
);

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        STORE = 2'd1,
        LOAD  = 2'd2,
        RESP  = 2'd3
    } state_t;

    // Wait counter only needs to reach MEM_LAT; keep at least one bit so the
    // MEM_LAT = 0 build still has a legal vector.
    localparam int              CW       = (MEM_LAT > 0) ? $clog2(MEM_LAT + 1) : 1;
    localparam logic [CW-1:0]   LAT_LAST = CW'(MEM_LAT);

    state_t        state;
    logic [7:0]    addr_q;
    logic [7:0]    wdata_q;
    logic [2:0]    rd_q;
    logic [CW-1:0] lat_cnt;

`ifdef LSU_STORE_FWD_EN
    logic          fwd_valid;
    logic [7:0]    fwd_addr;
    logic [7:0]    fwd_data;
`endif

    // The request fields are held in addr_q/wdata_q/rd_q from accept until the
    // unit is idle again, so the memory ports can simply mirror them.
    assign mem_waddr = addr_q;
    assign mem_wdata = wdata_q;
    assign mem_raddr = addr_q;
    assign rsp_rd    = rd_q;

    // req_ready, mem_en and rsp_valid are registered alongside the state so
    // every output that leaves the block comes straight from a flop.
    // NOTE: all state here uses non-blocking assignments so every flop samples
    // the pre-edge values of the others; blocking assignments would make the
    // result depend on statement order and break the simulation/synthesis match.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state     <= IDLE;
            req_ready <= 1'b1;
            mem_en    <= 1'b0;
            rsp_valid <= 1'b0;
            rsp_data  <= 8'h00;
            st_cnt    <= 8'h00;
            addr_q    <= 8'h00;
            wdata_q   <= 8'h00;
            rd_q      <= 3'd0;
            lat_cnt   <= '0;
`ifdef LSU_STORE_FWD_EN
            fwd_valid <= 1'b0;
            fwd_addr  <= 8'h00;
            fwd_data  <= 8'h00;
`endif
        end else begin
            case (state)
                IDLE: begin
                    if (req_valid) begin
                        addr_q    <= req_addr;
                        wdata_q   <= req_wdata;
                        rd_q      <= req_rd;
                        lat_cnt   <= '0;
                        req_ready <= 1'b0;
                        if (req_we) begin
                            state  <= STORE;
                            mem_en <= 1'b1;
                            st_cnt <= st_cnt + 8'd1;
`ifdef LSU_STORE_FWD_EN
                            fwd_valid <= 1'b1;
                            fwd_addr  <= req_addr;
                            fwd_data  <= req_wdata;
`endif
                        end else begin
`ifdef LSU_STORE_FWD_EN
                            // Hit on the last store: data is already known,
                            // so skip the memory wait entirely.
                            if (fwd_valid && (fwd_addr == req_addr)) begin
                                state     <= RESP;
                                rsp_valid <= 1'b1;
                                rsp_data  <= fwd_data;
                            end else begin
                                state <= LOAD;
                            end
`else
                            state <= LOAD;
`endif
                        end
                    end
                end

                STORE: begin
                    // Exactly one write cycle, no response.
                    state     <= IDLE;
                    mem_en    <= 1'b0;
                    req_ready <= 1'b1;
                end

                LOAD: begin
                    // mem_raddr has been stable since the accept edge; the
                    // last of the MEM_LAT+1 edges samples the memory.
                    if (lat_cnt == LAT_LAST) begin
                        state     <= RESP;
                        rsp_valid <= 1'b1;
                        rsp_data  <= mem_rdata;
                    end else begin
                        lat_cnt <= lat_cnt + 1'b1;
                    end
                end

                RESP: begin
                    // rsp_data/rsp_rd are untouched here, so they hold until
                    // the handshake completes, including in the first cycle.
                    if (rsp_ready) begin
                        state     <= IDLE;
                        rsp_valid <= 1'b0;
                        req_ready <= 1'b1;
                    end
                end

                default: begin
                    state     <= IDLE;
                    req_ready <= 1'b1;
                    mem_en    <= 1'b0;
                    rsp_valid <= 1'b0;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_load_store_unit.sv
// -----------------------------------------------------------------------------
// tb_load_store_unit
//
// Drives load_store_unit with directed scenarios and then randomized traffic.
// A transaction-level reference model (countdown per outstanding operation
// plus a byte array for memory) predicts every output each cycle; a compare
// process checks the DUT against it on every falling edge. Directed sections
// add hand-computed literal expectations.
// -----------------------------------------------------------------------------
module tb_load_store_unit;

`ifdef LSU_STORE_FWD_EN
    localparam int MEM_LAT = 2;
`else
    localparam int MEM_LAT = 0;
`endif

    logic       clk = 1'b0;
    logic       rst = 1'b0;
    logic       req_valid = 1'b0;
    logic       req_ready;
    logic       req_we = 1'b0;
    logic [7:0] req_addr = 8'h00;
    logic [7:0] req_wdata = 8'h00;
    logic [2:0] req_rd = 3'd0;
    logic       mem_en;
    logic [7:0] mem_waddr;
    logic [7:0] mem_wdata;
    logic [7:0] mem_raddr;
    logic [7:0] mem_rdata;
    logic       rsp_valid;
    logic       rsp_ready = 1'b0;
    logic [7:0] rsp_data;
    logic [2:0] rsp_rd;
    logic [7:0] st_cnt;

    int n_cmp = 0;
    int n_bad = 0;
    int pulse_cnt = 0;
    bit rsp_rand = 1'b0;

    always #5 clk = ~clk;

    load_store_unit #(.MEM_LAT(MEM_LAT)) dut (
        .clk       (clk),
        .rst       (rst),
        .req_valid (req_valid),
        .req_ready (req_ready),
        .req_we    (req_we),
        .req_addr  (req_addr),
        .req_wdata (req_wdata),
        .req_rd    (req_rd),
        .mem_en    (mem_en),
        .mem_waddr (mem_waddr),
        .mem_wdata (mem_wdata),
        .mem_raddr (mem_raddr),
        .mem_rdata (mem_rdata),
        .rsp_valid (rsp_valid),
        .rsp_ready (rsp_ready),
        .rsp_data  (rsp_data),
        .rsp_rd    (rsp_rd),
        .st_cnt    (st_cnt)
    );

    // Unwritten bytes read a fixed pattern; 0x20 is pinned to 0x3C.
    function automatic logic [7:0] pattern(input logic [7:0] a);
        logic [7:0] p;
        p = (a * 8'd29) ^ 8'h5A;
        if (a == 8'h20) p = 8'h3C;
        return p;
    endfunction

    // ---------------- data memory seen by the DUT ----------------
    logic [7:0] tb_mem [256];
    bit         tb_wr  [256];
    assign mem_rdata = tb_wr[mem_raddr] ? tb_mem[mem_raddr] : pattern(mem_raddr);

    always @(posedge clk) begin
        if (mem_en) begin
            tb_mem[mem_waddr] <= mem_wdata;
            tb_wr[mem_waddr]  <= 1'b1;
        end
    end

    // ---------------- reference model ----------------
    bit         m_store_pulse;
    bit         m_resp_pend;
    int         m_wait;
    logic [7:0] m_addr, m_wdata, m_rsp_data, m_st_cnt;
    logic [2:0] m_rd;
    logic [7:0] m_mem [256];
    bit         m_wr  [256];
    bit         m_fwd_valid;
    logic [7:0] m_fwd_addr;

    function automatic logic [7:0] m_read(input logic [7:0] a);
        return m_wr[a] ? m_mem[a] : pattern(a);
    endfunction

    always @(posedge clk or posedge rst) begin
        if (rst) begin
            m_store_pulse <= 1'b0;
            m_resp_pend   <= 1'b0;
            m_wait        <= 0;
            m_st_cnt      <= 8'h00;
            m_fwd_valid   <= 1'b0;
        end else if (m_store_pulse) begin
            m_store_pulse  <= 1'b0;
            m_mem[m_addr]  <= m_wdata;
            m_wr[m_addr]   <= 1'b1;
        end else if (m_wait != 0) begin
            m_wait <= m_wait - 1;
            if (m_wait == 1) m_resp_pend <= 1'b1;
        end else if (m_resp_pend) begin
            if (rsp_ready) m_resp_pend <= 1'b0;
        end else if (req_valid) begin
            m_addr <= req_addr;
            m_rd   <= req_rd;
            if (req_we) begin
                m_store_pulse <= 1'b1;
                m_wdata       <= req_wdata;
                m_st_cnt      <= m_st_cnt + 8'd1;
                m_fwd_valid   <= 1'b1;
                m_fwd_addr    <= req_addr;
            end else begin
                m_rsp_data <= m_read(req_addr);
`ifdef LSU_STORE_FWD_EN
                if (m_fwd_valid && m_fwd_addr == req_addr) m_resp_pend <= 1'b1;
                else                                       m_wait <= MEM_LAT + 1;
`else
                m_wait <= MEM_LAT + 1;
`endif
            end
        end
    end

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", name, act, exp, $time);
        end
    endtask

    // ---------------- per-cycle compare ----------------
    always @(negedge clk) begin
        if (rst) begin
            check("rst_req_ready", req_ready, 1);
            check("rst_mem_en",    mem_en, 0);
            check("rst_rsp_valid", rsp_valid, 0);
            check("rst_rsp_data",  rsp_data, 0);
            check("rst_rsp_rd",    rsp_rd, 0);
            check("rst_st_cnt",    st_cnt, 0);
            check("rst_mem_raddr", mem_raddr, 0);
            check("rst_mem_waddr", mem_waddr, 0);
            check("rst_mem_wdata", mem_wdata, 0);
        end else begin
            if (mem_en) pulse_cnt++;
            check("req_ready", req_ready, !(m_store_pulse || m_wait != 0 || m_resp_pend));
            check("mem_en", mem_en, m_store_pulse);
            if (m_store_pulse) begin
                check("mem_waddr", mem_waddr, m_addr);
                check("mem_wdata", mem_wdata, m_wdata);
            end
            if (m_wait != 0) check("mem_raddr", mem_raddr, m_addr);
            check("rsp_valid", rsp_valid, m_resp_pend);
            if (m_resp_pend) begin
                check("rsp_data", rsp_data, m_rsp_data);
                check("rsp_rd",   rsp_rd, m_rd);
            end
            check("st_cnt", st_cnt, m_st_cnt);
        end
    end

    // Random writeback back-pressure when enabled.
    initial begin
        forever begin
            @(posedge clk);
            #1;
            if (rsp_rand) rsp_ready = 1'($urandom_range(0, 1));
        end
    end

    // Present one request, hold it until accepted; returns 1 time unit after
    // the accept edge.
    task automatic send(input logic we, input logic [7:0] a, input logic [7:0] d,
                        input logic [2:0] rd);
        int n;
        req_we    = we;
        req_addr  = a;
        req_wdata = d;
        req_rd    = rd;
        req_valid = 1'b1;
        n = 0;
        forever begin
            @(negedge clk);
            if (req_ready) break;
            n++;
            if (n > 200) begin
                check("accept_timeout", 0, 1);
                break;
            end
        end
        @(posedge clk);
        #1;
        req_valid = 1'b0;
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic pulse_reset();
        rst = 1'b1;
        tick();
        rst = 1'b0;
    endtask

    initial begin
        int p0;
        rst = 1'b1;
        repeat (2) @(posedge clk);
        #1;
        check("lit_reset_ready",  req_ready, 1);
        check("lit_reset_st_cnt", st_cnt, 0);
        rst = 1'b0;
        tick();

        // Single store.
        send(1'b1, 8'h10, 8'hA5, 3'd0);
        check("lit_store_en",    mem_en, 1);
        check("lit_store_waddr", mem_waddr, 8'h10);
        check("lit_store_wdata", mem_wdata, 8'hA5);
        check("lit_store_cnt",   st_cnt, 1);
        check("lit_store_norsp", rsp_valid, 0);
        tick();
        check("lit_store_en_off", mem_en, 0);
        check("lit_store_norsp2", rsp_valid, 0);

        // Load with writeback stalled for four cycles.
        rsp_ready = 1'b0;
        send(1'b0, 8'h20, 8'h00, 3'd5);
        check("lit_load_wait", rsp_valid, 0);
        repeat (MEM_LAT + 1) tick();
        check("lit_load_valid", rsp_valid, 1);
        check("lit_load_data",  rsp_data, 8'h3C);
        check("lit_load_rd",    rsp_rd, 5);
        for (int i = 0; i < 4; i++) begin
            tick();
            check("lit_stall_valid", rsp_valid, 1);
            check("lit_stall_data",  rsp_data, 8'h3C);
            check("lit_stall_ready", req_ready, 0);
        end
        rsp_ready = 1'b1;
        tick();
        check("lit_release_ready", req_ready, 1);
        check("lit_release_valid", rsp_valid, 0);

        // rsp_ready already high on entry: single response cycle.
        send(1'b0, 8'h30, 8'h00, 3'd3);
        repeat (MEM_LAT + 1) tick();
        check("lit_fast_valid", rsp_valid, 1);
        check("lit_fast_data",  rsp_data, 8'h2A);
        tick();
        check("lit_fast_done", rsp_valid, 0);
        check("lit_fast_idle", req_ready, 1);
        rsp_ready = 1'b0;

        // 256 back-to-back stores wrap the counter.
        pulse_reset();
        p0 = pulse_cnt;
        for (int i = 0; i < 256; i++) begin
            send(1'b1, 8'(i), 8'(i) ^ 8'hFF, 3'd0);
            if (i == 254) check("lit_cnt_255", st_cnt, 8'd255);
        end
        tick();
        check("lit_cnt_wrap", st_cnt, 0);
        check("lit_pulses",   pulse_cnt - p0, 256);

        // Reset in the middle of a store.
        send(1'b1, 8'h55, 8'h99, 3'd0);
        rst = 1'b1;
        #1;
        check("lit_rst_store_en",    mem_en, 0);
        check("lit_rst_store_ready", req_ready, 1);
        tick();
        rst = 1'b0;

        // The aborted store never reached memory: 0x55 still holds 0x55^0xFF.
        send(1'b0, 8'h55, 8'h00, 3'd2);
        repeat (MEM_LAT + 1) tick();
        check("lit_after_rst_valid", rsp_valid, 1);
        check("lit_after_rst_data",  rsp_data, 8'hAA);
        rst = 1'b1;
        #1;
        check("lit_rst_resp_valid", rsp_valid, 0);
        check("lit_rst_resp_data",  rsp_data, 0);
        tick();
        rst = 1'b0;
        send(1'b1, 8'h66, 8'h12, 3'd0);
        check("lit_post_rst_en",  mem_en, 1);
        check("lit_post_rst_cnt", st_cnt, 1);
        tick();

`ifdef LSU_STORE_FWD_EN
        // Forwarded load answers one cycle after accept; a miss waits.
        send(1'b1, 8'h44, 8'h7E, 3'd0);
        tick();
        send(1'b0, 8'h44, 8'h00, 3'd1);
        check("lit_fwd_valid", rsp_valid, 1);
        check("lit_fwd_data",  rsp_data, 8'h7E);
        rsp_ready = 1'b1;
        tick();
        rsp_ready = 1'b0;
        send(1'b0, 8'h45, 8'h00, 3'd1);
        check("lit_miss_wait", rsp_valid, 0);
        repeat (MEM_LAT + 1) tick();
        check("lit_miss_valid", rsp_valid, 1);
        check("lit_miss_data",  rsp_data, 8'h45 ^ 8'hFF);
        rsp_ready = 1'b1;
        tick();
        rsp_ready = 1'b0;
`endif

        // Randomized traffic with back-pressure and occasional resets.
        rsp_rand = 1'b1;
        for (int i = 0; i < 400; i++) begin
            send(1'($urandom_range(0, 1)), 8'h40 + 8'($urandom_range(0, 15)),
                 8'($urandom), 3'($urandom));
            repeat ($urandom_range(0, 2)) tick();
            if ($urandom_range(0, 39) == 0) pulse_reset();
        end
        rsp_rand  = 1'b0;
        rsp_ready = 1'b1;
        repeat (MEM_LAT + 4) tick();

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
